// File: rtl/alert_ping_scheduler_if.sv
// Ping request/response bundle between the scheduler and the per-channel alert receivers.
// The master side is the scheduler; the slave side is the receiver bank.
interface alert_ping_scheduler_if #(
  parameter int unsigned NumAlerts = 4,
  parameter int unsigned IdxWidth  = $clog2(NumAlerts)
);
  logic [NumAlerts-1:0] ping_req_o;
  logic [NumAlerts-1:0] ping_ok_i;
  logic                 ping_fail_o;
  logic [IdxWidth-1:0]  fail_idx_o;
  logic                 busy_o;

  modport master (
    output ping_req_o,
    output ping_fail_o,
    output fail_idx_o,
    output busy_o,
    input  ping_ok_i
  );

  modport slave (
    input  ping_req_o,
    input  ping_fail_o,
    input  fail_idx_o,
    input  busy_o,
    output ping_ok_i
  );
endinterface

// File: rtl/alert_ping_scheduler.sv
// Round-robin ping scheduler: pings one enabled alert channel at a time after a
// programmable idle interval and flags channels that miss the response timeout.
module alert_ping_scheduler #(
  parameter int unsigned NumAlerts = 4,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned IdxWidth  = $clog2(NumAlerts)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NumAlerts-1:0] ping_en_mask_i,
  input  logic [CntWidth-1:0]  wait_cyc_i,
  input  logic [CntWidth-1:0]  timeout_cyc_i,
  alert_ping_scheduler_if.master ping_bus
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPing
  } state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic [IdxWidth-1:0]  last_idx_q, last_idx_d;
  logic                 fail_q, fail_d;
  logic [IdxWidth-1:0]  fail_idx_q, fail_idx_d;
  logic [NumAlerts-1:0] req_q, req_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [IdxWidth-1:0]  pick_idx;

  function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] base,
                                                   input int unsigned         off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumAlerts) sum = sum - NumAlerts;
    return IdxWidth'(sum);
  endfunction

  // Scan offsets from farthest to nearest so the nearest enabled channel after
  // last_idx_q wins; offset NumAlerts lands back on last_idx_q itself.
  always_comb begin
    found    = 1'b0;
    pick_idx = last_idx_q;
    for (int unsigned off = NumAlerts; off >= 1; off--) begin
      if (ping_en_mask_i[wrap_add(last_idx_q, off)]) begin
        found    = 1'b1;
        pick_idx = wrap_add(last_idx_q, off);
      end
    end
  end

  // NOTE: every signal assigned in this block gets its default first, so no
  // path through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    fail_d     = 1'b0;
    fail_idx_d = fail_idx_q;

    if (!en_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StWait;
          cnt_d   = '0;
        end
        StWait: begin
          // Increment only below the limit, so the counter can never wrap.
          if (cnt_q < wait_cyc_i) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (found) begin
              state_d    = StPing;
              idx_d      = pick_idx;
              last_idx_d = pick_idx;
            end
          end
        end
        StPing: begin
          // A response beats a coincident timeout; a masked-off channel aborts silently.
          if (ping_bus.ping_ok_i[idx_q] || !ping_en_mask_i[idx_q]) begin
            state_d = StWait;
            cnt_d   = '0;
          end else if (cnt_q >= timeout_cyc_i) begin
            state_d    = StWait;
            cnt_d      = '0;
            fail_d     = 1'b1;
            fail_idx_d = idx_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are precomputed from the next state so they leave flops directly.
  assign req_d  = (state_d == StPing) ? (NumAlerts'(1) << idx_d) : '0;
  assign busy_d = (state_d == StPing);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= IdxWidth'(NumAlerts - 1);
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      req_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
    end
  end

  assign ping_bus.ping_req_o  = req_q;
  assign ping_bus.ping_fail_o = fail_q;
  assign ping_bus.fail_idx_o  = fail_idx_q;
  assign ping_bus.busy_o      = busy_q;

endmodule

// File: tb/tb_alert_ping_scheduler.sv
// Scoreboard bench for alert_ping_scheduler: directed phases push expected ping
// and fail events; a negedge monitor pops and compares them as the DUT emits them.
module tb_alert_ping_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;

  typedef enum logic {EvReq, EvFail} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [3:0] val;   // one-hot request, or failing index
    int         len;   // expected request high cycles, -1 = don't care
    int         gap;   // expected low cycles before the request, -1 = don't care
  } ev_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic [N-1:0]  ping_en_mask_i;
  logic [CW-1:0] wait_cyc_i;
  logic [CW-1:0] timeout_cyc_i;

  int n_checks = 0;
  int n_fail   = 0;
  ev_t sb_q[$];

  // Receiver behaviour: 0 = never answer, 1 = answer on Ping cycle ok_cycle,
  // 2 = answer on every other channel (and on all channels outside Ping).
  int ok_mode  = 0;
  int ok_cycle = 0;

  alert_ping_scheduler_if #(.NumAlerts(N)) bus ();

  alert_ping_scheduler #(.NumAlerts(N), .CntWidth(CW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .ping_en_mask_i (ping_en_mask_i),
    .wait_cyc_i     (wait_cyc_i),
    .timeout_cyc_i  (timeout_cyc_i),
    .ping_bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [3:0] val, input int len, input int gap);
    sb_q.push_back('{kind: EvReq, val: val, len: len, gap: gap});
  endtask

  task automatic push_fail(input logic [3:0] idx);
    sb_q.push_back('{kind: EvFail, val: idx, len: -1, gap: -1});
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_req_high(input int budget);
    int n = 0;
    while (bus.ping_req_o == '0 && n < budget) begin
      step();
      n++;
    end
    check("wait_req_high", 32'(bus.ping_req_o != '0), 32'(1));
  endtask

  // Wait until every expected event was seen and the request is low, then disable.
  task automatic drain_and_stop(input string name, input int budget);
    int n = 0;
    while (!(sb_q.size() == 0 && bus.ping_req_o == '0) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(sb_q.size()), 32'(0));
    en_i = 1'b0;
    step();
    step();
  endtask

  // Receiver model, driving ok shortly after each rising edge.
  initial begin
    int k = 0;
    logic [N-1:0] prev = '0;
    bus.ping_ok_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (bus.ping_req_o != '0) k = (prev == '0) ? 1 : k + 1;
      case (ok_mode)
        1:       bus.ping_ok_i = (bus.ping_req_o != '0 && k == ok_cycle) ? bus.ping_req_o : '0;
        2:       bus.ping_ok_i = (bus.ping_req_o != '0) ? ~bus.ping_req_o : '1;
        default: bus.ping_ok_i = '0;
      endcase
      prev = bus.ping_req_o;
    end
  end

  // Monitor: pops an expected event whenever a request rises or a fail pulses.
  initial begin
    logic [N-1:0] prev_req = '0;
    logic         prev_fail = 1'b0;
    int           high_cnt = 0;
    int           low_cnt = 0;
    int           len_exp = -1;
    ev_t          e;
    forever begin
      @(negedge clk_i);
      check("busy_vs_req", 32'(bus.busy_o), 32'(bus.ping_req_o != '0));
      if (bus.ping_fail_o) begin
        check("fail_single_cycle", 32'(prev_fail), 32'(0));
        check("fail_expected", 32'(sb_q.size() != 0), 32'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("fail_kind", 32'(e.kind), 32'(EvFail));
          check("fail_idx", 32'(bus.fail_idx_o), 32'(e.val));
        end
      end
      if (bus.ping_req_o != '0 && prev_req == '0) begin
        check("req_expected", 32'(sb_q.size() != 0), 32'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("req_kind", 32'(e.kind), 32'(EvReq));
          check("req_value", 32'(bus.ping_req_o), 32'(e.val));
          if (e.gap >= 0) check("req_gap", 32'(low_cnt), 32'(e.gap));
          len_exp = e.len;
        end
        high_cnt = 0;
      end else if (bus.ping_req_o != '0 && bus.ping_req_o != prev_req) begin
        check("req_stable", 32'(bus.ping_req_o), 32'(prev_req));
      end
      if (bus.ping_req_o != '0) high_cnt++;
      if (bus.ping_req_o == '0 && prev_req != '0) begin
        if (len_exp >= 0) check("req_len", 32'(high_cnt), 32'(len_exp));
        low_cnt = 0;
      end
      if (bus.ping_req_o == '0) low_cnt++;
      prev_req  = bus.ping_req_o;
      prev_fail = bus.ping_fail_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hits = 0;
    int req_hits  = 0;
    rst_ni = 1'b1;
    en_i = 1'b0;
    ping_en_mask_i = '0;
    wait_cyc_i = '0;
    timeout_cyc_i = '0;
    #1 rst_ni = 1'b0;
    #1;
    check("reset_req", 32'(bus.ping_req_o), 32'(0));
    check("reset_fail", 32'(bus.ping_fail_o), 32'(0));
    check("reset_busy", 32'(bus.busy_o), 32'(0));
    check("reset_fail_idx", 32'(bus.fail_idx_o), 32'(0));
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Basic rotation; ok two cycles after each request.
    ping_en_mask_i = 4'b1111; wait_cyc_i = 3; timeout_cyc_i = 10;
    ok_mode = 1; ok_cycle = 3;
    push_req(4'b0001, 3, -1);
    push_req(4'b0010, 3, 4);
    push_req(4'b0100, 3, 4);
    push_req(4'b1000, 3, 4);
    push_req(4'b0001, 3, 4);
    en_i = 1'b1;
    drain_and_stop("basic_drain", 200);

    // Timeout on the only enabled channel, twice in a row.
    ping_en_mask_i = 4'b0100; wait_cyc_i = 0; timeout_cyc_i = 5; ok_mode = 0;
    push_req(4'b0100, 6, -1);
    push_fail(4'd2);
    push_req(4'b0100, 6, 1);
    push_fail(4'd2);
    en_i = 1'b1;
    drain_and_stop("timeout_drain", 200);

    // Masked rotation alternates between channels 3 and 1.
    ping_en_mask_i = 4'b1010; wait_cyc_i = 2; timeout_cyc_i = 10;
    ok_mode = 1; ok_cycle = 1;
    push_req(4'b1000, 1, -1);
    push_req(4'b0010, 1, 3);
    push_req(4'b1000, 1, 3);
    push_req(4'b0010, 1, 3);
    en_i = 1'b1;
    drain_and_stop("mask_drain", 200);

    // Mask cleared during Wait: no requests at all.
    wait_cyc_i = 5;
    en_i = 1'b1;
    step();
    step();
    step();
    ping_en_mask_i = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy_o) busy_hits++;
      if (bus.ping_req_o != '0) req_hits++;
    end
    check("mask0_busy_cycles", 32'(busy_hits), 32'(0));
    check("mask0_req_cycles", 32'(req_hits), 32'(0));
    check("fail_idx_held", 32'(bus.fail_idx_o), 32'(2));
    en_i = 1'b0;
    step();

    // Ok coincides with the timeout cycle: ok wins, no fail pulse.
    ping_en_mask_i = 4'b1111; wait_cyc_i = 1; timeout_cyc_i = 3;
    ok_mode = 1; ok_cycle = 4;
    push_req(4'b0100, 4, -1);
    push_req(4'b1000, 4, 2);
    en_i = 1'b1;
    drain_and_stop("race_drain", 200);

    // Ok only on non-selected channels (and everywhere outside Ping) is ignored.
    ok_mode = 2;
    push_req(4'b0001, 4, -1);
    push_fail(4'd0);
    en_i = 1'b1;
    drain_and_stop("wrong_ok_drain", 200);

    // Disable during the second Ping cycle: request drops, no fail.
    wait_cyc_i = 1; timeout_cyc_i = 10; ok_mode = 0;
    push_req(4'b0010, 2, -1);
    en_i = 1'b1;
    wait_req_high(50);
    step();
    en_i = 1'b0;
    step();
    check("abort_req_low", 32'(bus.ping_req_o), 32'(0));
    check("abort_no_fail", 32'(bus.ping_fail_o), 32'(0));
    step();
    check("abort_no_fail_late", 32'(bus.ping_fail_o), 32'(0));
    ok_mode = 1; ok_cycle = 1;
    push_req(4'b0100, 1, -1);
    en_i = 1'b1;
    drain_and_stop("reenable_drain", 200);

    // Reset in the middle of a ping to channel 0.
    ping_en_mask_i = 4'b0001; wait_cyc_i = 0; timeout_cyc_i = 10; ok_mode = 0;
    push_req(4'b0001, -1, -1);
    en_i = 1'b1;
    wait_req_high(50);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus.ping_req_o), 32'(0));
    check("rst_mid_fail", 32'(bus.ping_fail_o), 32'(0));
    check("rst_mid_busy", 32'(bus.busy_o), 32'(0));
    check("rst_mid_fail_idx", 32'(bus.fail_idx_o), 32'(0));
    ping_en_mask_i = 4'b1111;
    ok_mode = 1; ok_cycle = 2;
    push_req(4'b0001, 2, -1);
    step();
    rst_ni = 1'b1;
    drain_and_stop("post_reset_drain", 200);

    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alert_ping_scheduler.md
# alert_ping_scheduler

Periodic ping scheduler for a bank of alert channels. It picks enabled channels in round-robin order and issues one ping request at a time to the selected channel's alert receiver, which performs the ping handshake on the differential alert pair. It then waits for that channel's ping-ok and flags a failure if the response does not arrive within a programmable timeout. It sits between the alert-handler configuration registers and the per-channel ping inputs, so that lost or hung alert senders are detected.

## Interface
- NumAlerts, default 4: number of alert channels; 2..32.
- CntWidth, default 16: width of the wait and timeout counters.
- IdxWidth, default $clog2(NumAlerts): derived width of the channel index.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  scheduler enable; low forces Idle.
- ping_en_mask_i  in  NumAlerts  per-channel ping enable, sampled at selection time.
- wait_cyc_i  in  CntWidth  idle interval between pings, in cycles.
- timeout_cyc_i  in  CntWidth  ping response timeout, in cycles.
- ping_req_o  out  NumAlerts  one-hot level request to the selected channel; held until ok, timeout or abort.
- ping_ok_i  in  NumAlerts  per-channel ping-complete pulse from the receivers.
- ping_fail_o  out  1  one-cycle pulse on timeout.
- fail_idx_o  out  IdxWidth  index of the last timed-out channel; holds its value until the next failure.
- busy_o  out  1  high when the state is Ping.

## Operation
- State machine: Idle, Wait, Ping. The counter cnt_q is CntWidth wide and saturating. last_idx_q is IdxWidth wide.
- Reset: state Idle, cnt_q 0, last_idx_q NumAlerts-1, so the first pick is channel 0. All outputs are 0.
- Idle to Wait when en_i is high, with cnt_q cleared.
- Wait:
  - If cnt_q < wait_cyc_i, increment cnt_q.
  - Otherwise, select the first index with a set mask bit strictly after last_idx_q, wrapping modulo NumAlerts. The search may return last_idx_q itself if it is the only enabled channel.
  - If a channel is found, go to Ping, load idx_q and last_idx_q with it, and clear cnt_q.
  - If the mask is all zero, stay in Wait and clear cnt_q. The interval restarts and no ping is issued.
- Ping:
  - ping_req_o = 1 << idx_q. busy_o = 1.
  - If ping_ok_i[idx_q] is high, go to Wait and clear cnt_q.
  - Else if cnt_q >= timeout_cyc_i, go to Wait, clear cnt_q, set ping_fail_o for the next cycle only, and load fail_idx_o with idx_q.
  - Else increment cnt_q.
- ping_ok_i bits of non-selected channels, and any ping_ok_i outside Ping, are ignored. They have no effect on state, counter or outputs.
- Simultaneous ok and timeout in the same cycle: ok wins, and no fail is flagged.
- ping_en_mask_i[idx_q] dropping during Ping: abort. Go to Wait, clear cnt_q, no fail pulse.
- en_i low in any state: go to Idle the next cycle, clear cnt_q, drop ping_req_o, no fail pulse. last_idx_q is retained.
- wait_cyc_i and timeout_cyc_i may change at any time; they are compared every cycle.

## Timing
- ping_req_o, busy_o, ping_fail_o and fail_idx_o are all driven from registers. There is no combinational path from ping_ok_i or the mask to any output.
- Wait lasts wait_cyc_i+1 cycles. ping_req_o rises on the first cycle after Wait ends.
- From en_i rising (sampled at edge 0): Wait at cycle 1, ping_req_o high at cycle wait_cyc_i+2.
- ping_req_o stays high for at most timeout_cyc_i+1 cycles.
- Ok sampled in the k-th Ping cycle: ping_req_o falls in the following cycle.
- Timeout: ping_fail_o is high in the first cycle after ping_req_o falls, which is also the first Wait cycle.
- The gap between consecutive pings is at least wait_cyc_i+1 cycles with ping_req_o low.
- Reset asserted mid-Ping: ping_req_o and ping_fail_o are 0 asynchronously.

## Test plan
- Basic: NumAlerts=4, mask=4'b1111, wait=3, timeout=10, ok returned 2 cycles after each req. Required: req sequence 0001, 0010, 0100, 1000, 0001; 4 low cycles between pings; ping_fail_o never high.
- Timeout: mask=4'b0100, wait=0, timeout=5, ok never returned. Required: ping_req_o=4'b0100 for 6 cycles; then ping_fail_o pulses for 1 cycle with fail_idx_o=2; this repeats.
- Masking: mask=4'b1010. Required: req alternates 0010 and 1000. Mask set to 0 during Wait: no requests, busy_o stays 0.
- Race: timeout=3, ok[idx] asserted on the 4th Ping cycle, the timeout cycle. Required: no fail pulse. Ok on a non-selected channel: ignored, and a timeout still occurs.
- Abort: en_i dropped in the 2nd Ping cycle. Required: ping_req_o=0 the next cycle, no fail pulse. On re-enable, the next pick is the following channel.
- Reset mid-Ping with ping_req_o=4'b0001: all outputs 0 immediately. After release with en_i=1, the first pick is channel 0 again.
